// File: rtl/mlp_pkg.sv
// Shared constants and types for the quantised MLP frame loader.
package mlp_pkg;

  localparam int unsigned NUM_FEAT = 6;
  localparam int unsigned FEAT_W   = 4;
  localparam int unsigned CLS_W    = 2;
  localparam int unsigned VEC_W    = NUM_FEAT * FEAT_W;
  localparam int unsigned CNT_W    = $clog2(NUM_FEAT + 1);
  localparam int unsigned SET_W    = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef logic [FEAT_W-1:0] feat_t;
  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [CLS_W-1:0]  cls_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/mlp_frame_pack.sv
// Slot-indexed feature register file; slot k lives at bits [k*FEAT_W +: FEAT_W].
module mlp_frame_pack
  import mlp_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  we,
  input  cnt_t  idx,
  input  feat_t data,
  output vec_t  vec
);

  // Reset and clear wipe every slot; otherwise one slot is written per enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec <= '0;
    end else if (clr) begin
      vec <= '0;
    end else if (we) begin
      for (int k = 0; k < NUM_FEAT; k++) begin
        if (idx == CNT_W'(k)) begin
          vec[k*FEAT_W +: FEAT_W] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/mlp_frame_loader.sv
// Front end of the combinational MLP classifier: packs a feature frame,
// holds it for a settle window, captures the class and returns it.
// Optional build macro: MLP_FAULT_INJ_EN (adds fault_mask / fault_arm).
module mlp_frame_loader
  import mlp_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  feat_valid,
  output logic  feat_ready,
  input  feat_t feat_data,
  input  logic  feat_last,
  output vec_t  vec_o,
  input  cls_t  cls_i,
  output logic  res_valid,
  input  logic  res_ready,
  output cls_t  res_class,
  output logic  frame_err
`ifdef MLP_FAULT_INJ_EN
  ,
  input  vec_t  fault_mask,
  input  logic  fault_arm
`endif
);

  localparam cnt_t              LAST_IDX    = CNT_W'(NUM_FEAT - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  state_t            state, state_n;
  cnt_t              cnt, cnt_n;
  logic [SET_W-1:0]  settle, settle_n;
  logic              res_valid_n;
  cls_t              res_class_n;
  logic              frame_err_n;
  logic              feat_ready_n;
  logic              pack_we;
  logic              pack_clr;
  logic              beat_acc;
  vec_t              frame;

  assign beat_acc = feat_valid & feat_ready;

  mlp_frame_pack u_pack (
    .clk  (clk),
    .rst  (rst),
    .clr  (pack_clr),
    .we   (pack_we),
    .idx  (cnt),
    .data (feat_data),
    .vec  (frame)
  );

`ifdef MLP_FAULT_INJ_EN
  vec_t mask_q, mask_n;

  // Fault mask latched on settle entry, dropped when the result is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_n;
    end
  end

  assign vec_o = frame ^ mask_q;
`else
  assign vec_o = frame;
`endif

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      cnt        <= '0;
      settle     <= '0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      frame_err  <= 1'b0;
      feat_ready <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      settle     <= settle_n;
      res_valid  <= res_valid_n;
      res_class  <= res_class_n;
      frame_err  <= frame_err_n;
      feat_ready <= feat_ready_n;
    end
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    settle_n    = settle;
    res_valid_n = res_valid;
    res_class_n = res_class;
    frame_err_n = 1'b0;
    pack_we     = 1'b0;
    pack_clr    = 1'b0;
`ifdef MLP_FAULT_INJ_EN
    mask_n      = mask_q;
`endif

    case (state)
      LOAD: begin
        if (beat_acc) begin
          if (cnt == LAST_IDX) begin
            if (feat_last) begin
              pack_we  = 1'b1;
              cnt_n    = cnt + CNT_W'(1);
              settle_n = SETTLE_LOAD;
              state_n  = SETTLE;
`ifdef MLP_FAULT_INJ_EN
              mask_n   = fault_arm ? fault_mask : '0;
`endif
            end else begin
              // Long frame: drop this beat and swallow the rest of the frame.
              frame_err_n = 1'b1;
              pack_clr    = 1'b1;
              cnt_n       = '0;
              state_n     = DRAIN;
            end
          end else if (feat_last) begin
            // Short frame: discard everything collected so far.
            frame_err_n = 1'b1;
            pack_clr    = 1'b1;
            cnt_n       = '0;
          end else begin
            pack_we = 1'b1;
            cnt_n   = cnt + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        if (beat_acc && feat_last) begin
          cnt_n   = '0;
          state_n = LOAD;
        end
      end

      SETTLE: begin
        if (settle == '0) begin
          res_class_n = cls_i;
          res_valid_n = 1'b1;
          state_n     = HOLD;
        end else begin
          settle_n = settle - SET_W'(1);
        end
      end

      HOLD: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          cnt_n       = '0;
          state_n     = LOAD;
`ifdef MLP_FAULT_INJ_EN
          mask_n      = '0;
`endif
        end
      end

      default: begin
        state_n = LOAD;
      end
    endcase

    feat_ready_n = (state_n == LOAD) || (state_n == DRAIN);
  end

endmodule

// File: doc/mlp_frame_loader.md
Name: mlp_frame_loader

Overview:
- Upstream front end of the combinational quantised MLP classifier.
- Accepts 4-bit sensor features one per valid/ready beat and packs a frame of NUM_FEAT features into the classifier's flat input vector.
- Holds that vector stable for a programmable settle window to cover the slow printed combinational path, then captures the classifier's argmax index and returns it over a valid/ready result handshake.
- Detects malformed frames.

Parameters:
- NUM_FEAT, 6, features per frame.
- FEAT_W, 4, bits per feature.
- CLS_W, 2, width of class index returned by classifier.
- SETTLE_CYC, 3, cycles vec_o is held before cls_i is sampled; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- feat_valid  in  1  feature beat valid.
- feat_ready  out  1  loader accepts feature.
- feat_data  in  FEAT_W  unsigned feature value.
- feat_last  in  1  marks final feature of frame.
- vec_o  out  NUM_FEAT*FEAT_W  packed vector to classifier; feature k at bits [k*FEAT_W +: FEAT_W].
- cls_i  in  CLS_W  classifier argmax index (combinational return).
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_class  out  CLS_W  registered class index.
- frame_err  out  1  one-cycle pulse: frame discarded.

Behaviour:
- Reset values (synchronous, dominant over all other inputs):
  - state=LOAD, feat count=0, vec_o=0, res_valid=0, res_class=0, frame_err=0, settle counter=0.
  - Reset mid-frame or mid-settle discards all partial data.
- Transfers occur only when valid and ready are both high on a rising edge.
- State LOAD:
  - feat_ready=1.
  - Each accepted beat writes feat_data into slot cnt; cnt increments.
  - Accepted beat with feat_last=1 and cnt==NUM_FEAT-1: go to SETTLE, settle counter loaded with SETTLE_CYC-1.
  - Accepted beat with feat_last=1 and cnt!=NUM_FEAT-1 (short frame): frame_err pulses next cycle, cnt=0, vec_o cleared to 0, stay LOAD.
  - Accepted beat at cnt==NUM_FEAT-1 with feat_last=0 (long frame): frame_err pulses, beat dropped, vec_o cleared, enter DRAIN.
- State DRAIN:
  - feat_ready=1; beats are discarded.
  - Accepted beat with feat_last=1: go to LOAD, cnt=0.
- State SETTLE:
  - feat_ready=0; vec_o frozen.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: res_class<=cls_i, res_valid<=1, go to HOLD.
  - Latency: last feature accepted at edge T gives res_valid high after edge T+SETTLE_CYC.
- State HOLD:
  - feat_ready=0; res_valid=1; res_class and vec_o stable.
  - res_ready=1: res_valid<=0, cnt=0, go to LOAD; vec_o retains old value until overwritten slot by slot.
- Unwritten slots are never exposed: a frame only leaves LOAD when all NUM_FEAT slots are written.
- cnt width: clog2(NUM_FEAT+1). Counters never wrap.
- No feature is accepted in the cycle a result is consumed; next frame begins the following cycle.
- frame_err is always exactly one cycle wide.

Optional Feature:
- Macro: MLP_FAULT_INJ_EN.
- When defined:
  - Adds input fault_mask (NUM_FEAT*FEAT_W) and input fault_arm (1).
  - fault_arm is sampled when entering SETTLE. If it is high, vec_o during SETTLE/HOLD equals the packed frame XOR fault_mask. This emulates input bit flips for fault analysis.
  - The mask is latched on SETTLE entry and held constant for the frame.
- When undefined: ports absent; vec_o is the packed frame unmodified.

Decomposition:
- Shared package mlp_pkg:
  - FEAT_W, NUM_FEAT, CLS_W defaults.
  - VEC_W = NUM_FEAT*FEAT_W.
  - state enum {LOAD, DRAIN, SETTLE, HOLD}.
  - Typedefs feat_t, vec_t, cls_t.
- One natural sub-module: mlp_frame_pack, the slot-indexed register file with clear and write-enable, producing vec_o.
- The FSM and counters stay in mlp_frame_loader.

Test Plan:
- Normal frame: features 1,2,3,4,5,6 (last on 6th), cls_i=2'b01, SETTLE_CYC=3, res_ready=1 -> vec_o=24'h654321, res_valid rises 3 cycles after last beat, res_class=01, feat_ready returns next cycle.
- Short frame: 3 beats with feat_last on 3rd -> frame_err one-cycle pulse, vec_o=0, no res_valid; following 6-beat frame classifies normally.
- Long frame: 8 beats, feat_last on 8th -> frame_err pulse at 6th+1 beat, beats 7-8 drained, no result; next frame is accepted cleanly.
- Backpressure: res_ready=0 for 10 cycles in HOLD with cls_i toggling -> res_class stays at value captured at settle end, feat_ready=0, extra feat_valid beats not accepted.
- Reset in SETTLE (rst high 1 cycle) -> next cycle res_valid=0, vec_o=0, feat_ready=1, cnt=0.
- MLP_FAULT_INJ_EN: frame 24'h654321, fault_mask=24'h000001, fault_arm=1 -> vec_o=24'h654320 during SETTLE/HOLD; with fault_arm=0 -> vec_o=24'h654321.
